padring_enable_seq: RTL and testbench

Power-up/power-down sequencer for the IO pad ring. It sits between the core-side enable request and the pad-group enable pins of the IO cells. It waits for the pad supply (VSS/VDD pad pair) to report good and debounces it. It then enables pad groups one at a time at fixed intervals and tears them down in reverse order. Supply loss during operation forces an immediate safe shutdown and latches a fault.

---
 rtl/padring_enable_seq.sv | 166 ++++++++++++++++
 tb/tb_padring_enable_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/padring_enable_seq.sv
`default_nettype none
// ============================================================================
// Module   : padring_enable_seq
// Function : IO pad-ring sequencer: debounced supply check, staged group
//            enable, reverse-order teardown, sticky fault on supply loss.
// Revision : 1.0
// ============================================================================
module padring_enable_seq #(
  parameter int NGROUPS  = 4,
  parameter int DEBOUNCE = 16,
  parameter int STEP     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwr_ok,
  input  logic               en_req,
  output logic [NGROUPS-1:0] grp_en,
  output logic               ready,
  output logic               busy,
  output logic               fault
);

  localparam int c_cnt_max = (DEBOUNCE > STEP) ? DEBOUNCE : STEP;
  localparam int c_cnt_w   = $clog2(c_cnt_max);
  localparam int c_idx_w   = $clog2(NGROUPS + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEBOUNCE - 1);
  localparam logic [c_cnt_w-1:0] c_step_last = c_cnt_w'(STEP - 1);
  localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);
  localparam logic [c_idx_w-1:0] c_idx_full  = c_idx_w'(NGROUPS);
  localparam logic [NGROUPS-1:0] c_grp_first = NGROUPS'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_RAMP     = 3'd2,
    S_ON       = 3'd3,
    S_DOWN     = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_pwr_meta;
  logic                 r_pwr_s;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic [NGROUPS-1:0]   r_grp_en;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_fault;
  logic                 w_pads_live;

  // States in which at least one group is, or is about to be, driven.
  assign w_pads_live = (r_state == S_RAMP) || (r_state == S_ON) || (r_state == S_DOWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwr_meta <= 1'b0;
      r_pwr_s    <= 1'b0;
    end else begin
      r_pwr_meta <= pwr_ok;
      r_pwr_s    <= r_pwr_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_grp_en <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_fault  <= 1'b0;
    end else if (w_pads_live && !r_pwr_s) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_grp_en <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_fault  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_fault) begin
            if (!en_req) r_fault <= 1'b0;
          end else if (r_pwr_s && en_req) begin
            r_state <= S_DEBOUNCE;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (!r_pwr_s || !en_req) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_deb_last) begin
            r_state  <= S_RAMP;
            r_grp_en <= c_grp_first;
            r_idx    <= c_idx_one;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        S_RAMP: begin
          if (!en_req) begin
            r_state <= S_DOWN;
            r_cnt   <= '0;
          end else if (r_cnt == c_step_last) begin
            r_cnt <= '0;
            if (r_idx == c_idx_full) begin
              r_state <= S_ON;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_grp_en <= (r_grp_en << 1) | c_grp_first;
              r_idx    <= r_idx + c_idx_one;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        S_ON: begin
          if (!en_req) begin
            r_state <= S_DOWN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_DOWN: begin
          // grp_en is a thermometer code, so shifting right drops the highest group.
          if (r_cnt == c_step_last) begin
            r_cnt    <= '0;
            r_grp_en <= r_grp_en >> 1;
            r_idx    <= r_idx - c_idx_one;
            if (r_idx == c_idx_one) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_idx    <= '0;
          r_grp_en <= '0;
          r_ready  <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign grp_en = r_grp_en;
  assign ready  = r_ready;
  assign busy   = r_busy;
  assign fault  = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_padring_enable_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_padring_enable_seq
// Function : Self-checking bench for padring_enable_seq; expected waveforms are
//            computed from event times (start edge E, stop edge D) arithmetically.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_padring_enable_seq;

  localparam int NGROUPS  = 4;
  localparam int DEBOUNCE = 16;
  localparam int STEP     = 8;

  logic               clk    = 1'b0;
  logic               rst_n  = 1'b1;
  logic               pwr_ok = 1'b1;
  logic               en_req = 1'b1;
  logic [NGROUPS-1:0] grp_en;
  logic               ready;
  logic               busy;
  logic               fault;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int e_start = 0;

  always #5 clk = ~clk;

  padring_enable_seq #(.NGROUPS(NGROUPS), .DEBOUNCE(DEBOUNCE), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_ok(pwr_ok), .en_req(en_req),
    .grp_en(grp_en), .ready(ready), .busy(busy), .fault(fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Number of groups that should be on at edge t for a ramp starting at edge e.
  function automatic int ramp_count(input int t, input int e);
    int n;
    if (t < e + DEBOUNCE) return 0;
    n = 1 + (t - e - DEBOUNCE) / STEP;
    return (n > NGROUPS) ? NGROUPS : n;
  endfunction

  function automatic logic [NGROUPS-1:0] therm(input int n);
    logic [NGROUPS-1:0] m;
    m = '0;
    for (int i = 0; i < NGROUPS; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({grp_en, ready, busy, fault} !== '0)
      begin errors++; $display("FAIL reset_async got=%b want=%b", {grp_en, ready, busy, fault}, 7'b0); end
    repeat (3) tick();
    checks++;
    if ({grp_en, ready, busy, fault} !== '0)
      begin errors++; $display("FAIL reset_held got=%b want=%b", {grp_en, ready, busy, fault}, 7'b0); end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_power_up();
    logic [NGROUPS+2:0] want;
    int   t_on;
    int   pt_cyc [4] = '{19, 27, 35, 43};
    logic [3:0] pt_grp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    t_on = 3 + DEBOUNCE + NGROUPS * STEP;
    while (cyc < t_on + 2) begin
      tick();
      want = {therm(ramp_count(cyc, 3)), (cyc >= t_on), (cyc >= 3 && cyc < t_on), 1'b0};
      checks++;
      if ({grp_en, ready, busy, fault} !== want)
        begin errors++; $display("FAIL power_up cyc=%0d got=%b want=%b", cyc, {grp_en, ready, busy, fault}, want); end
      for (int i = 0; i < 4; i++) begin
        if (cyc == pt_cyc[i]) begin
          checks++;
          if (grp_en !== pt_grp[i])
            begin errors++; $display("FAIL power_up_point cyc=%0d got=%b want=%b", cyc, grp_en, pt_grp[i]); end
        end
      end
    end
  endtask

  task automatic test_power_down();
    logic [NGROUPS+2:0] want;
    int hold, d, n;
    hold = $urandom_range(1, 10);
    repeat (hold) begin
      tick();
      checks++;
      if ({grp_en, ready, busy, fault} !== {{NGROUPS{1'b1}}, 3'b100})
        begin errors++; $display("FAIL on_hold cyc=%0d got=%b", cyc, {grp_en, ready, busy, fault}); end
    end
    en_req = 1'b0;
    d = cyc + 1;
    while (cyc < d + NGROUPS * STEP + 3) begin
      tick();
      n = NGROUPS - (cyc - d) / STEP;
      if (n < 0) n = 0;
      want = {therm(n), 1'b0, (cyc < d + NGROUPS * STEP), 1'b0};
      checks++;
      if ({grp_en, ready, busy, fault} !== want)
        begin errors++; $display("FAIL power_down cyc=%0d got=%b want=%b", cyc, {grp_en, ready, busy, fault}, want); end
      // en_req is don't-care while tearing down; only the first IDLE sample must be low.
      en_req = (cyc + 1 <= d + NGROUPS * STEP) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic test_debounce_reject();
    logic [NGROUPS+2:0] want;
    int e, g, l, e2, t_on;
    logic exp_ready, exp_busy;
    en_req = 1'b1;
    e  = cyc + 1;
    g  = e + $urandom_range(0, 10);
    l  = $urandom_range(1, 3);
    e2 = g + l + 3;
    t_on = e2 + DEBOUNCE + NGROUPS * STEP;
    while (cyc < t_on + 1) begin
      tick();
      exp_ready = (cyc >= t_on);
      exp_busy  = (cyc >= e && cyc < g + 3) || (cyc >= e2 && !exp_ready);
      want = {therm(ramp_count(cyc, e2)), exp_ready, exp_busy, 1'b0};
      checks++;
      if ({grp_en, ready, busy, fault} !== want)
        begin errors++; $display("FAIL debounce_reject cyc=%0d got=%b want=%b", cyc, {grp_en, ready, busy, fault}, want); end
      if (cyc == g)     pwr_ok = 1'b0;
      if (cyc == g + l) pwr_ok = 1'b1;
    end
  endtask

  task automatic test_supply_loss();
    logic [NGROUPS+2:0] want;
    int hold, drop, coin, f;
    hold = $urandom_range(0, 5);
    drop = $urandom_range(1, 4);
    coin = $urandom_range(0, 1);
    repeat (hold) tick();
    f = cyc;
    pwr_ok = 1'b0;
    while (cyc < f + 3 + DEBOUNCE + 8) begin
      tick();
      want = (cyc < f + 3) ? {{NGROUPS{1'b1}}, 3'b100} : {{NGROUPS{1'b0}}, 3'b001};
      checks++;
      if ({grp_en, ready, busy, fault} !== want)
        begin errors++; $display("FAIL supply_loss cyc=%0d got=%b want=%b", cyc, {grp_en, ready, busy, fault}, want); end
      if (cyc == f + drop) pwr_ok = 1'b1;
      if (coin != 0 && cyc == f + 2) en_req = 1'b0;
      if (cyc == f + 3) en_req = 1'b1;
    end
    en_req = 1'b0;
    tick();
    checks++;
    if ({grp_en, ready, busy, fault} !== {{NGROUPS{1'b0}}, 3'b000})
      begin errors++; $display("FAIL fault_clear cyc=%0d got=%b", cyc, {grp_en, ready, busy, fault}); end
    en_req  = 1'b1;
    e_start = cyc + 1;
  endtask

  task automatic test_abort(input int e);
    logic [NGROUPS+2:0] want;
    int a1, a, n;
    a1 = e + DEBOUNCE + STEP + $urandom_range(0, STEP - 2);
    while (cyc < a1) begin
      tick();
      want = {therm(ramp_count(cyc, e)), 1'b0, (cyc >= e), 1'b0};
      checks++;
      if ({grp_en, ready, busy, fault} !== want)
        begin errors++; $display("FAIL restart_ramp cyc=%0d got=%b want=%b", cyc, {grp_en, ready, busy, fault}, want); end
    end
    en_req = 1'b0;
    a = cyc + 1;
    while (cyc < a + 2 * STEP + 3) begin
      tick();
      n = 2 - (cyc - a) / STEP;
      if (n < 0) n = 0;
      want = {therm(n), 1'b0, (cyc < a + 2 * STEP), 1'b0};
      checks++;
      if ({grp_en, ready, busy, fault} !== want)
        begin errors++; $display("FAIL abort cyc=%0d got=%b want=%b", cyc, {grp_en, ready, busy, fault}, want); end
    end
  endtask

  task automatic test_async_reset();
    logic [NGROUPS+2:0] want;
    int e, k;
    en_req = 1'b1;
    e = cyc + 1;
    k = $urandom_range(DEBOUNCE + 1, DEBOUNCE + NGROUPS * STEP - 1);
    while (cyc < e + k) begin
      tick();
      want = {therm(ramp_count(cyc, e)), 1'b0, 1'b1, 1'b0};
      checks++;
      if ({grp_en, ready, busy, fault} !== want)
        begin errors++; $display("FAIL pre_reset_ramp cyc=%0d got=%b want=%b", cyc, {grp_en, ready, busy, fault}, want); end
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({grp_en, ready, busy, fault} !== '0)
      begin errors++; $display("FAIL async_reset_immediate got=%b want=%b", {grp_en, ready, busy, fault}, 7'b0); end
    tick();
    rst_n = 1'b1;
    cyc   = 0;
    while (cyc < 3 + DEBOUNCE + STEP) begin
      tick();
      want = {therm(ramp_count(cyc, 3)), 1'b0, (cyc >= 3), 1'b0};
      checks++;
      if ({grp_en, ready, busy, fault} !== want)
        begin errors++; $display("FAIL post_reset_ramp cyc=%0d got=%b want=%b", cyc, {grp_en, ready, busy, fault}, want); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_debounce_reject();
    test_supply_loss();
    test_abort(e_start);
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
